// File: rtl/system_memory_arb_pkg.sv
// Shared widths, requester index and pending-read record for the s2 port arbiter.
package system_memory_arb_pkg;

  localparam int DEF_ADDR_W    = 17;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_BE_W      = 4;
  localparam int DEF_MEM_WORDS = 78036;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } req_idx_t;

  typedef struct packed {
    logic     vld;
    req_idx_t owner;
    logic     oor;
  } rd_pend_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered priority pointer.
// The pointer moves to the losing side on every granted cycle; idle cycles hold it.
module rr_arb2
  import system_memory_arb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  output logic [1:0] o_gnt
);

  req_idx_t r_prio;

  always_comb begin
    o_gnt = i_req;
    if (&i_req) begin
      o_gnt = (r_prio == M1) ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_prio <= M0;
    end else if (i_upd && (|o_gnt)) begin
      r_prio <= o_gnt[0] ? M1 : M0;
    end
  end

endmodule

// File: rtl/system_memory_s2_arbiter.sv
// Shares memory port s2 between the scanout reader (m0) and the blitter (m1), one transfer
// per cycle, round-robin, with a fixed 1-cycle read return to the owner.
module system_memory_s2_arbiter
  import system_memory_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BE_W      = DEF_BE_W,
  parameter int MEM_WORDS = DEF_MEM_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              err_range,
  output logic              err_rw
);

  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_WORDS);

  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_any;
  req_idx_t          w_sel;
  logic              w_rd;
  logic              w_wr;
  logic              w_in_range;
  logic              w_rvld;
  logic [DATA_W-1:0] w_rdata;
  rd_pend_t          r_rd;
  logic              r_err_range;
  logic              r_err_rw;

  // Requests are masked in reset so nothing is granted and the pointer stays put.
  assign w_req = {m1_read | m1_write, m0_read | m0_write} & {2{~reset}};

  rr_arb2 u_arb (
    .i_clk   (clk),
    .i_reset (reset),
    .i_req   (w_req),
    .i_upd   (~reset),
    .o_gnt   (w_gnt)
  );

  assign w_any = |w_gnt;
  assign w_sel = w_gnt[1] ? M1 : M0;

  always_comb begin
    mem_address    = m0_address;
    mem_byteenable = m0_byteenable;
    mem_writedata  = m0_writedata;
    w_rd           = m0_read;
    w_wr           = m0_write;
    if (w_sel == M1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      w_rd           = m1_read;
      w_wr           = m1_write;
    end
  end

  assign w_in_range     = (mem_address < MEM_LIMIT);
  assign mem_chipselect = w_any & w_in_range;
  assign mem_write      = w_any & w_wr & w_in_range;
  assign mem_clken      = 1'b1;

  assign m0_waitrequest = reset | (w_req[0] & ~w_gnt[0]);
  assign m1_waitrequest = reset | (w_req[1] & ~w_gnt[1]);

  // Read+write together is treated as a write, so it never creates a pending read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd        <= '0;
      r_err_range <= 1'b0;
      r_err_rw    <= 1'b0;
    end else begin
      r_rd.vld   <= w_any & w_rd & ~w_wr;
      r_rd.owner <= w_sel;
      r_rd.oor   <= ~w_in_range;
      if (w_any && !w_in_range) begin
        r_err_range <= 1'b1;
      end
      if (w_any && w_rd && w_wr) begin
        r_err_rw <= 1'b1;
      end
    end
  end

  assign w_rvld  = r_rd.vld & ~reset;
  assign w_rdata = r_rd.oor ? '0 : mem_readdata;

  assign m0_readdatavalid = w_rvld & (r_rd.owner == M0);
  assign m1_readdatavalid = w_rvld & (r_rd.owner == M1);
  assign m0_readdata      = m0_readdatavalid ? w_rdata : '0;
  assign m1_readdata      = m1_readdatavalid ? w_rdata : '0;

  assign err_range = r_err_range;
  assign err_rw    = r_err_rw;

endmodule

// File: tb/tb_system_memory_s2_arbiter.sv
// Bench for the s2 arbiter: per-cycle vector table against a behavioural s2 RAM, plus
// hand-written latency and pipelining sequences.
module tb_system_memory_s2_arbiter;

  localparam logic [1:0] NO = 2'b00;
  localparam logic [1:0] RD = 2'b01;
  localparam logic [1:0] WR = 2'b10;
  localparam logic [1:0] RW = 2'b11;

  logic        clk;
  logic        reset;
  logic [16:0] m0_address, m1_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [16:0] mem_address;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        err_range, err_rw;

  int total = 0;
  int bad   = 0;

  system_memory_s2_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .m0_address       (m0_address),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_byteenable    (m0_byteenable),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_byteenable    (m1_byteenable),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_byteenable   (mem_byteenable),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata),
    .err_range        (err_range),
    .err_rw           (err_rw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural s2 RAM: registered address, q valid the cycle after the access edge.
  logic [31:0] ram [0:78035];
  logic        ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      ram[10]    <= 32'h0000A00A;
      ram[20]    <= 32'h0000B014;
      ram[78035] <= 32'hCAFEF00D;
      ram_init   <= 1'b1;
    end else if (mem_chipselect && mem_clken && (mem_address < 17'd78036)) begin
      mem_readdata <= ram[mem_address];
      if (mem_write) begin
        for (int i = 0; i < 4; i++) begin
          if (mem_byteenable[i]) ram[mem_address][8*i +: 8] <= mem_writedata[8*i +: 8];
        end
      end
    end
  end

  typedef struct packed {
    logic        rst;
    logic [1:0]  op0;
    logic [16:0] a0;
    logic [3:0]  b0;
    logic [31:0] d0;
    logic [1:0]  op1;
    logic [16:0] a1;
    logic [3:0]  b1;
    logic [31:0] d1;
    logic [1:0]  x_wt;
    logic        x_v0;
    logic [31:0] x_q0;
    logic        x_v1;
    logic [31:0] x_q1;
    logic        x_cs;
    logic        x_we;
    logic        x_er;
    logic        x_ew;
  } vec_t;

  function automatic vec_t mk(logic rst, logic [1:0] op0, int a0, logic [3:0] b0, logic [31:0] d0,
                              logic [1:0] op1, int a1, logic [3:0] b1, logic [31:0] d1,
                              logic [1:0] wt, logic v0, logic [31:0] q0, logic v1, logic [31:0] q1,
                              logic cs, logic we, logic er, logic ew);
    vec_t v;
    v.rst = rst;  v.op0 = op0; v.a0 = a0[16:0]; v.b0 = b0; v.d0 = d0;
    v.op1 = op1;  v.a1 = a1[16:0]; v.b1 = b1; v.d1 = d1;
    v.x_wt = wt;  v.x_v0 = v0; v.x_q0 = q0; v.x_v1 = v1; v.x_q1 = q1;
    v.x_cs = cs;  v.x_we = we; v.x_er = er; v.x_ew = ew;
    return v;
  endfunction

  task automatic chk(input int idx, input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL step%0d %s: got %h, expected %h", idx, nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [1:0] op0, input logic [16:0] a0, input logic [3:0] b0,
                       input logic [31:0] d0, input logic [1:0] op1, input logic [16:0] a1,
                       input logic [3:0] b1, input logic [31:0] d1);
    reset = rst;
    m0_read = op0[0]; m0_write = op0[1]; m0_address = a0; m0_byteenable = b0; m0_writedata = d0;
    m1_read = op1[0]; m1_write = op1[1]; m1_address = a1; m1_byteenable = b1; m1_writedata = d1;
  endtask

  vec_t vt [0:26];

  initial begin
    // wt = {m1_waitrequest, m0_waitrequest}; outputs are those seen during the same cycle.
    vt[0]  = mk(1, RD, 5, 4'hF, 0, RD, 6, 4'hF, 0,           2'b11, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[1]  = mk(0, NO, 0, 4'h0, 0, NO, 0, 4'h0, 0,           2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[2]  = mk(0, RD, 5, 4'hF, 0, NO, 0, 4'h0, 0,           2'b00, 0, 0, 0, 0, 1, 0, 0, 0);
    vt[3]  = mk(1, NO, 0, 4'h0, 0, RD, 6, 4'hF, 0,           2'b11, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[4]  = mk(0, RD, 10, 4'hF, 0, RD, 20, 4'hF, 0,         2'b10, 0, 0, 0, 0, 1, 0, 0, 0);
    vt[5]  = mk(0, RD, 10, 4'hF, 0, RD, 20, 4'hF, 0,         2'b01, 1, 32'h0000A00A, 0, 0, 1, 0, 0, 0);
    vt[6]  = mk(0, RD, 10, 4'hF, 0, RD, 20, 4'hF, 0,         2'b10, 0, 0, 1, 32'h0000B014, 1, 0, 0, 0);
    vt[7]  = mk(0, RD, 10, 4'hF, 0, RD, 20, 4'hF, 0,         2'b01, 1, 32'h0000A00A, 0, 0, 1, 0, 0, 0);
    vt[8]  = mk(0, NO, 0, 4'h0, 0, NO, 0, 4'h0, 0,           2'b00, 0, 0, 1, 32'h0000B014, 0, 0, 0, 0);
    vt[9]  = mk(0, WR, 100, 4'hF, 32'hDEADBEEF, NO, 0, 4'h0, 0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0);
    vt[10] = mk(0, RD, 100, 4'hF, 0, NO, 0, 4'h0, 0,         2'b00, 0, 0, 0, 0, 1, 0, 0, 0);
    vt[11] = mk(0, NO, 0, 4'h0, 0, NO, 0, 4'h0, 0,           2'b00, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    vt[12] = mk(0, NO, 0, 4'h0, 0, WR, 7, 4'hF, 32'h11223344, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0);
    vt[13] = mk(0, NO, 0, 4'h0, 0, WR, 7, 4'h1, 32'h000000AA, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0);
    vt[14] = mk(0, NO, 0, 4'h0, 0, RD, 7, 4'hF, 0,           2'b00, 0, 0, 0, 0, 1, 0, 0, 0);
    vt[15] = mk(0, NO, 0, 4'h0, 0, NO, 0, 4'h0, 0,           2'b00, 0, 0, 1, 32'h112233AA, 0, 0, 0, 0);
    vt[16] = mk(0, NO, 0, 4'h0, 0, WR, 78036, 4'hF, 32'hFFFFFFFF, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[17] = mk(0, NO, 0, 4'h0, 0, RD, 78036, 4'hF, 0,       2'b00, 0, 0, 0, 0, 0, 0, 1, 0);
    vt[18] = mk(0, NO, 0, 4'h0, 0, NO, 0, 4'h0, 0,           2'b00, 0, 0, 1, 0, 0, 0, 1, 0);
    vt[19] = mk(0, RW, 3, 4'hF, 32'h5, NO, 0, 4'h0, 0,       2'b00, 0, 0, 0, 0, 1, 1, 1, 0);
    vt[20] = mk(0, NO, 0, 4'h0, 0, NO, 0, 4'h0, 0,           2'b00, 0, 0, 0, 0, 0, 0, 1, 1);
    vt[21] = mk(0, RD, 3, 4'hF, 0, NO, 0, 4'h0, 0,           2'b00, 0, 0, 0, 0, 1, 0, 1, 1);
    vt[22] = mk(0, NO, 0, 4'h0, 0, NO, 0, 4'h0, 0,           2'b00, 1, 32'h5, 0, 0, 0, 0, 1, 1);
    vt[23] = mk(0, NO, 0, 4'h0, 0, RD, 78035, 4'hF, 0,       2'b00, 0, 0, 0, 0, 1, 0, 1, 1);
    vt[24] = mk(0, NO, 0, 4'h0, 0, NO, 0, 4'h0, 0,           2'b00, 0, 0, 1, 32'hCAFEF00D, 0, 0, 1, 1);
    vt[25] = mk(1, NO, 0, 4'h0, 0, NO, 0, 4'h0, 0,           2'b11, 0, 0, 0, 0, 0, 0, 1, 1);
    vt[26] = mk(0, NO, 0, 4'h0, 0, NO, 0, 4'h0, 0,           2'b00, 0, 0, 0, 0, 0, 0, 0, 0);

    drive(1, NO, 0, 0, 0, NO, 0, 0, 0);
    mem_readdata = 32'h0;
    repeat (3) @(posedge clk);

    for (int i = 0; i <= 26; i++) begin
      @(posedge clk);
      #1;
      drive(vt[i].rst, vt[i].op0, vt[i].a0, vt[i].b0, vt[i].d0,
            vt[i].op1, vt[i].a1, vt[i].b1, vt[i].d1);
      #3;
      chk(i, "m0_waitrequest",   {31'd0, m0_waitrequest},   {31'd0, vt[i].x_wt[0]});
      chk(i, "m1_waitrequest",   {31'd0, m1_waitrequest},   {31'd0, vt[i].x_wt[1]});
      chk(i, "m0_readdatavalid", {31'd0, m0_readdatavalid}, {31'd0, vt[i].x_v0});
      chk(i, "m0_readdata",      m0_readdata,               vt[i].x_q0);
      chk(i, "m1_readdatavalid", {31'd0, m1_readdatavalid}, {31'd0, vt[i].x_v1});
      chk(i, "m1_readdata",      m1_readdata,               vt[i].x_q1);
      chk(i, "mem_chipselect",   {31'd0, mem_chipselect},   {31'd0, vt[i].x_cs});
      chk(i, "mem_write",        {31'd0, mem_write},        {31'd0, vt[i].x_we});
      chk(i, "err_range",        {31'd0, err_range},        {31'd0, vt[i].x_er});
      chk(i, "err_rw",           {31'd0, err_rw},           {31'd0, vt[i].x_ew});
      chk(i, "mem_clken",        {31'd0, mem_clken},        32'd1);
    end

    // Read latency measured with a bounded wait: data must appear exactly one cycle later.
    begin
      int lat;
      @(posedge clk); #1;
      drive(0, RD, 17'd20, 4'hF, 0, NO, 0, 0, 0);
      #3;
      chk(100, "lat_issue_addr", {15'd0, mem_address}, 32'd20);
      @(posedge clk); #1;
      drive(0, NO, 0, 0, 0, NO, 0, 0, 0);
      #3;
      lat = 1;
      while (!m0_readdatavalid && lat < 5) begin
        @(posedge clk); #4;
        lat++;
      end
      chk(101, "lat_cycles", lat, 32'd1);
      chk(102, "lat_data", m0_readdata, 32'h0000B014);
    end

    // Back-to-back reads from one requester return one word per cycle in order.
    @(posedge clk); #1;
    drive(0, RD, 17'd10, 4'hF, 0, NO, 0, 0, 0);
    #3;
    chk(110, "b2b_wait0", {31'd0, m0_waitrequest}, 32'd0);
    @(posedge clk); #1;
    drive(0, RD, 17'd20, 4'hF, 0, NO, 0, 0, 0);
    #3;
    chk(111, "b2b_rdv_a", {31'd0, m0_readdatavalid}, 32'd1);
    chk(111, "b2b_data_a", m0_readdata, 32'h0000A00A);
    chk(111, "b2b_m1_rdv", {31'd0, m1_readdatavalid}, 32'd0);
    @(posedge clk); #1;
    drive(0, NO, 0, 0, 0, NO, 0, 0, 0);
    #3;
    chk(112, "b2b_rdv_b", {31'd0, m0_readdatavalid}, 32'd1);
    chk(112, "b2b_data_b", m0_readdata, 32'h0000B014);
    @(posedge clk); #4;
    chk(113, "b2b_idle_rdv", {31'd0, m0_readdatavalid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
